// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: run/resume control, instruction handshake and PC/status outputs.
// master = the sequencer, slave = the instruction source / tile environment.
interface fetch_sequencer_if #(
    parameter int PC_W = 8,
    parameter int IW   = 8
);
    logic            run;
    logic            resume;
    logic [IW-1:0]   instr_in;
    logic            instr_valid;
    logic            instr_req;
    logic            idle;
    logic            halted;
    logic [PC_W-1:0] pc;
    logic [IW-3:0]   cnt;

    modport master (
        input  run, resume, instr_in, instr_valid,
        output instr_req, idle, halted, pc, cnt
    );

    modport slave (
        output run, resume, instr_in, instr_valid,
        input  instr_req, idle, halted, pc, cnt
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: IDLE -> FETCH -> EXEC loop with NOP/JMP/LDC/DJNZ and HALT word.
// Define FETCH_SEQ_DJNZ_EN to enable the loop counter (LDC/DJNZ); otherwise those opcodes are NOPs.
module fetch_sequencer #(
    parameter int            PC_W    = 8,
    parameter int            IW      = 8,
    parameter logic [IW-1:0] HALT_OP = IW'(42)
) (
    input  logic             clk,
    input  logic             rst,
    fetch_sequencer_if.master bus
);
    localparam int CW = IW - 2;

    localparam logic [1:0] OP_JMP = 2'b01;
`ifdef FETCH_SEQ_DJNZ_EN
    localparam logic [1:0] OP_LDC  = 2'b10;
    localparam logic [1:0] OP_DJNZ = 2'b11;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          r_state, w_state_next;
    logic [PC_W-1:0] r_pc, w_pc_next;
    logic [IW-1:0]   r_ir, w_ir_next;
    logic [1:0]      w_op;
    logic [CW-1:0]   w_imm;
    logic [PC_W-1:0] w_target;

    assign w_op  = r_ir[IW-1:IW-2];
    assign w_imm = r_ir[IW-3:0];

    // Branch target: immediate zero-extended or truncated to the PC width.
    generate
        for (genvar gi = 0; gi < PC_W; gi++) begin : g_target
            if (gi < CW) begin : g_bit
                assign w_target[gi] = w_imm[gi];
            end else begin : g_zero
                assign w_target[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef FETCH_SEQ_DJNZ_EN
    logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_dec;
    assign w_cnt_dec = r_cnt - CW'(1);
`endif

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
`ifdef FETCH_SEQ_DJNZ_EN
        w_cnt_next   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.instr_valid) begin
                    w_ir_next    = bus.instr_in;
                    w_pc_next    = r_pc + PC_W'(1);
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_ir == HALT_OP) begin
                    w_state_next = S_HALT;
                end else begin
                    w_state_next = S_IDLE;
                    case (w_op)
                        OP_JMP: w_pc_next = w_target;
`ifdef FETCH_SEQ_DJNZ_EN
                        OP_LDC: w_cnt_next = w_imm;
                        OP_DJNZ: begin
                            w_cnt_next = w_cnt_dec;
                            if (w_cnt_dec != '0) w_pc_next = w_target;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_HALT: begin
                if (bus.resume) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
        end
    end

`ifdef FETCH_SEQ_DJNZ_EN
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_cnt_next;
    end
    assign bus.cnt = r_cnt;
`else
    assign bus.cnt = '0;
`endif

    assign bus.instr_req = (r_state == S_FETCH);
    assign bus.idle      = (r_state == S_IDLE);
    assign bus.halted    = (r_state == S_HALT);
    assign bus.pc        = r_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; expected fetch PCs are queued when an
// instruction step is started and popped when the sequencer raises instr_req.
module tb_fetch_sequencer;
    localparam int PC_W = 8;
    localparam int IW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_W(PC_W), .IW(IW)) bus();

    fetch_sequencer #(
        .PC_W   (PC_W),
        .IW     (IW),
        .HALT_OP(8'h2A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int ord[$];
    int cex[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_idle"},   32'(bus.idle),      32'd1);
        check({tag, "_req"},    32'(bus.instr_req), 32'd0);
        check({tag, "_halted"}, 32'(bus.halted),    32'd0);
        check({tag, "_pc"},     32'(bus.pc),        32'd0);
        check({tag, "_cnt"},    32'(bus.cnt),       32'd0);
        $display("reset %s: pc=%0d cnt=%0d idle=%0b", tag, bus.pc, bus.cnt, bus.idle);
    endtask

    task automatic do_reset(input string tag);
        rst             = 1'b1;
        bus.run         = 1'b0;
        bus.resume      = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;
        tick();
        rst = 1'b0;
        check_reset(tag);
    endtask

    // One instruction: wait for the request, check the fetch PC, supply the word, run EXEC.
    task automatic step(input logic [7:0] word, input int fetch_pc);
        int exp_pc;
        exp_q.push_back(fetch_pc);
        bus.run = 1'b1;
        for (int i = 0; i < 8 && !bus.instr_req; i++) tick();
        check("req_seen", 32'(bus.instr_req), 32'd1);
        exp_pc = exp_q.pop_front();
        check("fetch_pc", 32'(bus.pc), 32'(exp_pc));
        bus.instr_in    = word;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("pc_inc",   32'(bus.pc),        32'((exp_pc + 1) & 255));
        check("exec_req", 32'(bus.instr_req), 32'd0);
        tick();
        $display("instr %02h @pc=%0d -> pc=%0d cnt=%0d halted=%0b",
                 word, exp_pc, bus.pc, bus.cnt, bus.halted);
    endtask

    function automatic logic [7:0] prog_word(input int addr);
        case (addr)
            0:       return 8'h83;
            2:       return 8'hC1;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        bus.run         = 1'b0;
        bus.resume      = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_in    = '0;

        // NOP stream across the PC wrap
        do_reset("rst0");
        for (int i = 0; i <= 256; i++) step(8'h00, i & 255);
        check("wrap_pc", 32'(bus.pc), 32'd1);

        // JMP 5
        do_reset("rst_jmp");
        step(8'h45, 0);
        check("jmp_pc", 32'(bus.pc), 32'd5);
        step(8'h00, 5);

        // LDC 3 / DJNZ loop
        do_reset("rst_loop");
`ifdef FETCH_SEQ_DJNZ_EN
        ord = '{0, 1, 2, 1, 2, 1, 2};
        cex = '{3, 3, 2, 2, 1, 1, 0};
`else
        ord = '{0, 1, 2};
        cex = '{0, 0, 0};
`endif
        foreach (ord[k]) begin
            step(prog_word(ord[k]), ord[k]);
            check("loop_cnt", 32'(bus.cnt), 32'(cex[k]));
        end
        check("loop_pc", 32'(bus.pc), 32'd3);
        // DJNZ with cnt=0 wraps to all-ones and branches
        step(8'hC1, 3);
`ifdef FETCH_SEQ_DJNZ_EN
        check("djnz0_pc",  32'(bus.pc),  32'd1);
        check("djnz0_cnt", 32'(bus.cnt), 32'd63);
`else
        check("djnz0_pc",  32'(bus.pc),  32'd4);
        check("djnz0_cnt", 32'(bus.cnt), 32'd0);
`endif

        // HALT at pc=4, stays halted with run=1, resume returns to IDLE
        do_reset("rst_halt");
        step(8'h44, 0);
        check("halt_jmp_pc", 32'(bus.pc), 32'd4);
        step(8'h2A, 4);
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_pc",   32'(bus.pc),     32'd5);
        check("halt_idle", 32'(bus.idle),   32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_req",  32'(bus.instr_req), 32'd0);
            check("halt_stay", 32'(bus.halted),    32'd1);
        end
        bus.resume = 1'b1;
        tick();
        bus.resume = 1'b0;
        check("resume_idle",   32'(bus.idle),   32'd1);
        check("resume_halted", 32'(bus.halted), 32'd0);
        $display("resume: pc=%0d idle=%0b", bus.pc, bus.idle);
        step(8'h00, 5);

        // FETCH stall with run toggling
        do_reset("rst_stall");
        bus.run = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.run         = i[0];
            bus.instr_valid = 1'b0;
            tick();
            check("stall_req", 32'(bus.instr_req), 32'd1);
            check("stall_pc",  32'(bus.pc),        32'd0);
        end
        $display("stall: 10 cycles, pc=%0d req=%0b", bus.pc, bus.instr_req);
        step(8'h00, 0);

        // Reset during EXEC of DJNZ
        do_reset("rst_pre_exec");
        step(8'h85, 0);
`ifdef FETCH_SEQ_DJNZ_EN
        check("ldc5_cnt", 32'(bus.cnt), 32'd5);
`else
        check("ldc5_cnt", 32'(bus.cnt), 32'd0);
`endif
        bus.run = 1'b1;
        tick();
        check("pre_exec_req", 32'(bus.instr_req), 32'd1);
        bus.instr_in    = 8'hC1;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        check("in_exec_req", 32'(bus.instr_req), 32'd0);
        check("in_exec_pc",  32'(bus.pc),        32'd2);
        do_reset("rst_in_exec");

        // Reset during HALT
        step(8'h2A, 0);
        check("pre_rst_halted", 32'(bus.halted), 32'd1);
        bus.resume = 1'b1;
        do_reset("rst_in_halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
